addr_cal: RTL and testbench

- Per-sprite pixel address generator for the tile/sprite display path.
- Each cycle, decides whether the current raster position (hcount, vcount) falls inside one sprite instance.
- If it does, computes the sprite-ROM pixel address for that position, including repeat (tiling) and horizontal flip.
- One instance per sprite child; the display block ORs/prioritises the valid outputs and looks up colour from the address.

---
 rtl/addr_cal.sv | 89 ++++++++
 tb/tb_addr_cal.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/addr_cal.sv
// addr_cal: per-sprite pixel address generator.
// Decides whether the raster position (hcount, vcount) lies inside one sprite
// instance. On a hit it produces the sprite-ROM pixel address for that
// position, with pattern repeat (tiling) and optional horizontal flip.
// The outputs are registered, so there is one cycle of latency.
// Optional build macro: ADDR_CAL_VFLIP_EN makes sprite_info[9] a vertical-flip bit.
module addr_cal #(
   parameter int ADDR_W  = 16,
   parameter int COORD_W = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5*ADDR_W-1:0]   pattern_info,
   input  logic [31:0]           sprite_info,
   input  logic [COORD_W-1:0]    hcount,
   input  logic [COORD_W-1:0]    vcount,
   output logic [ADDR_W-1:0]     addr_output,
   output logic                  valid
);

   // One extra bit so that x+disp_w and y+disp_h can never wrap
   localparam int CMP_W = ADDR_W + 1;

   logic [ADDR_W-1:0]  base, spr_w, spr_h, disp_w, disp_h;
   logic               visible, hflip;
   logic [9:0]         spr_x, spr_y;
   logic [CMP_W-1:0]   h_e, v_e, x_e, y_e;
   logic               in_x, in_y, dims_ok, hit;
   logic [ADDR_W-1:0]  col, row, line_off;
   logic               valid_d, valid_q;
   logic [ADDR_W-1:0]  addr_d, addr_q;
   logic               unused_rsvd;

   assign base    = pattern_info[5*ADDR_W-1:4*ADDR_W];
   assign spr_w   = pattern_info[4*ADDR_W-1:3*ADDR_W];
   assign spr_h   = pattern_info[3*ADDR_W-1:2*ADDR_W];
   assign disp_w  = pattern_info[2*ADDR_W-1:ADDR_W];
   assign disp_h  = pattern_info[ADDR_W-1:0];
   assign visible = sprite_info[31];
   assign hflip   = sprite_info[30];
   assign spr_x   = sprite_info[29:20];
   assign spr_y   = sprite_info[19:10];

   // Reserved field is ignored (bit 9 may be consumed as vflip below)
   assign unused_rsvd = ^sprite_info[9:0];

   // Hit test and address computation for the current raster position
   always_comb begin
      h_e      = CMP_W'(hcount);
      v_e      = CMP_W'(vcount);
      x_e      = CMP_W'(spr_x);
      y_e      = CMP_W'(spr_y);
      in_x     = (h_e >= x_e) && (h_e < (x_e + CMP_W'(disp_w)));
      in_y     = (v_e >= y_e) && (v_e < (y_e + CMP_W'(disp_h)));
      dims_ok  = (spr_w != '0) && (spr_h != '0) && (disp_w != '0) && (disp_h != '0);
      hit      = visible && in_x && in_y && dims_ok;

      // Masking by size-1 gives the repeat; exact for power-of-two sizes
      col = (h_e[ADDR_W-1:0] - x_e[ADDR_W-1:0]) & (spr_w - 1'b1);
      if (hflip)
         col = spr_w - 1'b1 - col;
      row = (v_e[ADDR_W-1:0] - y_e[ADDR_W-1:0]) & (spr_h - 1'b1);
`ifdef ADDR_CAL_VFLIP_EN
      if (sprite_info[9])
         row = spr_h - 1'b1 - row;
`endif
      line_off = row * spr_w;

      valid_d = hit;
      addr_d  = '0;
      if (hit)
         addr_d = base + line_off + col;
   end

   // Output registers, cleared asynchronously while reset is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign valid       = valid_q;
   assign addr_output = addr_q;

endmodule

// File: tb/tb_addr_cal.sv
// Directed testbench for addr_cal with hand-computed expected values.
module tb_addr_cal;

   logic        clk;
   logic        reset;
   logic [79:0] pattern_info;
   logic [31:0] sprite_info;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [15:0] addr_output;
   logic        valid;

   int n_checks = 0;
   int n_errors = 0;

   addr_cal #(.ADDR_W(16), .COORD_W(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .pattern_info (pattern_info),
      .sprite_info  (sprite_info),
      .hcount       (hcount),
      .vcount       (vcount),
      .addr_output  (addr_output),
      .valid        (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [79:0] pat(input int b, input int sw, input int sh,
                                       input int dw, input int dh);
      pat = {b[15:0], sw[15:0], sh[15:0], dw[15:0], dh[15:0]};
   endfunction

   function automatic logic [31:0] spr(input bit vis, input bit hf, input int x,
                                       input int y, input int rsvd);
      spr = {vis, hf, x[9:0], y[9:0], rsvd[9:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive inputs, let one rising edge sample them, then look at outputs
   task automatic step(input logic [79:0] p, input logic [31:0] s,
                       input int h, input int v);
      pattern_info = p;
      sprite_info  = s;
      hcount       = h[9:0];
      vcount       = v[9:0];
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input bit ev, input int ea);
      chk({tag, ".valid"}, {31'b0, valid}, {31'b0, ev});
      chk({tag, ".addr"}, {16'b0, addr_output}, ea);
   endtask

   logic [79:0] p_a, p_b;
   int vflip_exp;

   initial begin
      p_a = pat(0, 32, 16, 32, 16);
      p_b = pat(544, 32, 1, 32, 128);
      reset        = 1'b0;
      pattern_info = p_a;
      sprite_info  = spr(1, 0, 100, 50, 0);
      hcount       = 10'd100;
      vcount       = 10'd50;

      // Held in reset even with a hit on the inputs
      @(posedge clk); #1;
      expect_out("rst_hold", 0, 0);
      @(negedge clk);
      reset = 1'b1;

      // Corners of the basic sprite
      step(p_a, spr(1, 0, 100, 50, 0), 100, 50);   expect_out("topleft", 1, 0);
      step(p_a, spr(1, 0, 100, 50, 0), 131, 65);   expect_out("botright", 1, 511);
      step(p_a, spr(1, 0, 100, 50, 0), 105, 52);   expect_out("inner", 1, 69);

      // Edges: left/top inclusive, right/bottom exclusive
      step(p_a, spr(1, 0, 100, 50, 0), 132, 50);   expect_out("right_excl", 0, 0);
      step(p_a, spr(1, 0, 100, 50, 0), 100, 66);   expect_out("bot_excl", 0, 0);
      step(p_a, spr(1, 0, 100, 50, 0), 99, 50);    expect_out("left_out", 0, 0);
      step(p_a, spr(1, 0, 100, 50, 0), 100, 49);   expect_out("top_out", 0, 0);

      // Horizontal flip
      step(p_a, spr(1, 1, 100, 50, 0), 100, 50);   expect_out("hflip_l", 1, 31);
      step(p_a, spr(1, 1, 100, 50, 0), 131, 50);   expect_out("hflip_r", 1, 0);
      step(p_a, spr(1, 1, 100, 50, 0), 101, 51);   expect_out("hflip_r1", 1, 62);

      // Row repeat with a one-line pattern
      step(p_b, spr(1, 0, 100, 66, 0), 105, 193);  expect_out("repeat", 1, 549);
      step(p_b, spr(1, 0, 100, 66, 0), 105, 194);  expect_out("repeat_end", 0, 0);

      // Column repeat: display 64 wide over a 16-wide pattern
      step(pat(1000, 16, 16, 64, 16), spr(1, 0, 0, 0, 0), 37, 2);
      expect_out("col_repeat", 1, 1000 + 2*16 + 5);

      // Invisible sprite and zero-size fields
      step(p_a, spr(0, 0, 100, 50, 0), 100, 50);   expect_out("invisible", 0, 0);
      step(pat(0, 32, 0, 32, 16), spr(1, 0, 100, 50, 0), 100, 50);
      expect_out("spr_h0", 0, 0);
      step(pat(0, 32, 16, 0, 16), spr(1, 0, 100, 50, 0), 100, 50);
      expect_out("disp_w0", 0, 0);

      // Address wraps modulo 2^16
      step(pat(65530, 32, 16, 32, 16), spr(1, 0, 100, 50, 0), 110, 50);
      expect_out("wrap", 1, 4);

      // Sprite near the right edge of coordinate space: x+disp_w exceeds 10 bits
      step(pat(0, 32, 16, 32, 16), spr(1, 0, 1000, 0, 0), 1023, 0);
      expect_out("far_right", 1, 23);

      // Reserved bits ignored, bit 9 is vflip only in the feature build
`ifdef ADDR_CAL_VFLIP_EN
      vflip_exp = 480;
`else
      vflip_exp = 0;
`endif
      step(p_a, spr(1, 0, 100, 50, 10'h200), 100, 50);
      expect_out("bit9", 1, vflip_exp);
      step(p_a, spr(1, 0, 100, 50, 10'h1FF), 100, 50);
      expect_out("rsvd_low", 1, 0);

      // Asynchronous reset mid-frame
      step(p_a, spr(1, 0, 100, 50, 0), 131, 65);   expect_out("pre_rst", 1, 511);
      #2;
      reset = 1'b0;
      #1;
      expect_out("async_rst", 0, 0);
      @(posedge clk); #1;
      expect_out("rst_held", 0, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      expect_out("rel_before_edge", 0, 0);
      @(posedge clk); #1;
      expect_out("resume", 1, 511);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
